// File: rtl/color_histogram.sv
`default_nettype none
// ============================================================================
// Module   : color_histogram
// Purpose  : Counts colour-filtered pixels inside a centred inner frame, split
//            into column bins, and publishes per-bin counts and partial sums.
// Revision : 1.0
// ============================================================================
module color_histogram #(
    parameter int c_img_cols     = 160,
    parameter int c_img_rows     = 120,
    parameter int c_inframe_cols = 128,
    parameter int c_inframe_rows = 104,
    parameter int c_hist_bins    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start_i,
    input  logic        px_valid_i,
    input  logic        px_color_i,
    output logic [13:0] colorpxls_o,
    output logic [10:0] colorpxls_bin0_o,
    output logic [10:0] colorpxls_bin1_o,
    output logic [10:0] colorpxls_bin2_o,
    output logic [10:0] colorpxls_bin3_o,
    output logic [10:0] colorpxls_bin4_o,
    output logic [10:0] colorpxls_bin5_o,
    output logic [10:0] colorpxls_bin6_o,
    output logic [10:0] colorpxls_bin7_o,
    output logic [12:0] colorpxls_left_o,
    output logic [12:0] colorpxls_rght_o,
    output logic [12:0] colorpxls_bin012_o,
    output logic [12:0] colorpxls_bin567_o,
    output logic [12:0] colorpxls_bin01_o,
    output logic [12:0] colorpxls_bin67_o,
    output logic        new_frame_proc_o
);

    localparam logic [7:0] c_col_lo    = 8'((c_img_cols - c_inframe_cols) / 2);
    localparam logic [7:0] c_col_hi    = 8'((c_img_cols + c_inframe_cols) / 2 - 1);
    localparam logic [6:0] c_row_lo    = 7'((c_img_rows - c_inframe_rows) / 2);
    localparam logic [6:0] c_row_hi    = 7'((c_img_rows + c_inframe_rows) / 2 - 1);
    localparam logic [7:0] c_col_last  = 8'(c_img_cols - 1);
    localparam logic [6:0] c_row_last  = 7'(c_img_rows - 1);
    localparam int         c_bin_shift = $clog2(c_inframe_cols / c_hist_bins);
    localparam int         c_bin_w     = $clog2(c_hist_bins);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]         col;
    logic [7:0]         col_nxt;
    logic [6:0]         row;
    logic [6:0]         row_nxt;
    logic [7:0]         pix_col;
    logic [6:0]         pix_row;
    logic [7:0]         col_off;
    logic [c_bin_w-1:0] bin_idx;
    logic               accept;
    logic               hit;
    logic               last_px;

    logic [10:0] acc     [c_hist_bins];
    logic [10:0] acc_nxt [c_hist_bins];

    logic [12:0] sum01;
    logic [12:0] sum012;
    logic [12:0] sum_left;
    logic [12:0] sum67;
    logic [12:0] sum567;
    logic [12:0] sum_rght;
    logic [13:0] sum_total;

    // A frame start restarts indexing, so a pixel in that same cycle is (0,0).
    always_comb begin
        accept  = px_valid_i && (frame_start_i || (state == CAPTURE));
        pix_col = frame_start_i ? 8'd0 : col;
        pix_row = frame_start_i ? 7'd0 : row;
        last_px = accept && (pix_col == c_col_last) && (pix_row == c_row_last);
        hit     = accept && px_color_i
                  && (pix_col >= c_col_lo) && (pix_col <= c_col_hi)
                  && (pix_row >= c_row_lo) && (pix_row <= c_row_hi);
        col_off = pix_col - c_col_lo;
        bin_idx = c_bin_w'(col_off >> c_bin_shift);
    end

    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (frame_start_i) begin
            col_nxt = 8'd0;
            row_nxt = 7'd0;
        end
        if (accept) begin
            if (pix_col == c_col_last) begin
                col_nxt = 8'd0;
                row_nxt = pix_row + 7'd1;
            end else begin
                col_nxt = pix_col + 8'd1;
                row_nxt = pix_row;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < c_hist_bins; b++) begin
            acc_nxt[b] = frame_start_i ? 11'd0 : acc[b];
        end
        if (hit) begin
            acc_nxt[bin_idx] = acc_nxt[bin_idx] + 11'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            CAPTURE: if (last_px) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (frame_start_i) begin
            state_nxt = CAPTURE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col   <= 8'd0;
            row   <= 7'd0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    generate
        for (genvar gb = 0; gb < c_hist_bins; gb++) begin : g_bins
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc[gb] <= 11'd0;
                end else begin
                    acc[gb] <= acc_nxt[gb];
                end
            end
        end
    endgenerate

    // Widened before adding so that no partial sum can wrap.
    always_comb begin
        sum01     = 13'(acc[0]) + 13'(acc[1]);
        sum012    = sum01 + 13'(acc[2]);
        sum_left  = sum012 + 13'(acc[3]);
        sum67     = 13'(acc[6]) + 13'(acc[7]);
        sum567    = sum67 + 13'(acc[5]);
        sum_rght  = sum567 + 13'(acc[4]);
        sum_total = 14'(sum_left) + 14'(sum_rght);
    end

    // DONE is the only cycle in which the accumulators hold a finished frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colorpxls_o        <= 14'd0;
            colorpxls_bin0_o   <= 11'd0;
            colorpxls_bin1_o   <= 11'd0;
            colorpxls_bin2_o   <= 11'd0;
            colorpxls_bin3_o   <= 11'd0;
            colorpxls_bin4_o   <= 11'd0;
            colorpxls_bin5_o   <= 11'd0;
            colorpxls_bin6_o   <= 11'd0;
            colorpxls_bin7_o   <= 11'd0;
            colorpxls_left_o   <= 13'd0;
            colorpxls_rght_o   <= 13'd0;
            colorpxls_bin012_o <= 13'd0;
            colorpxls_bin567_o <= 13'd0;
            colorpxls_bin01_o  <= 13'd0;
            colorpxls_bin67_o  <= 13'd0;
            new_frame_proc_o   <= 1'b0;
        end else begin
            new_frame_proc_o <= (state == DONE);
            if (state == DONE) begin
                colorpxls_o        <= sum_total;
                colorpxls_bin0_o   <= acc[0];
                colorpxls_bin1_o   <= acc[1];
                colorpxls_bin2_o   <= acc[2];
                colorpxls_bin3_o   <= acc[3];
                colorpxls_bin4_o   <= acc[4];
                colorpxls_bin5_o   <= acc[5];
                colorpxls_bin6_o   <= acc[6];
                colorpxls_bin7_o   <= acc[7];
                colorpxls_left_o   <= sum_left;
                colorpxls_rght_o   <= sum_rght;
                colorpxls_bin012_o <= sum012;
                colorpxls_bin567_o <= sum567;
                colorpxls_bin01_o  <= sum01;
                colorpxls_bin67_o  <= sum67;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_color_histogram.sv
`default_nettype none
// Self-checking bench for color_histogram: randomized pixel streams compared
// against a coordinate-based histogram model.
module tb_color_histogram;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start_i;
    logic        px_valid_i;
    logic        px_color_i;
    logic [13:0] colorpxls_o;
    logic [10:0] colorpxls_bin0_o, colorpxls_bin1_o, colorpxls_bin2_o, colorpxls_bin3_o;
    logic [10:0] colorpxls_bin4_o, colorpxls_bin5_o, colorpxls_bin6_o, colorpxls_bin7_o;
    logic [12:0] colorpxls_left_o, colorpxls_rght_o;
    logic [12:0] colorpxls_bin012_o, colorpxls_bin567_o, colorpxls_bin01_o, colorpxls_bin67_o;
    logic        new_frame_proc_o;

    color_histogram dut (
        .clk                (clk),
        .rst                (rst),
        .frame_start_i      (frame_start_i),
        .px_valid_i         (px_valid_i),
        .px_color_i         (px_color_i),
        .colorpxls_o        (colorpxls_o),
        .colorpxls_bin0_o   (colorpxls_bin0_o),
        .colorpxls_bin1_o   (colorpxls_bin1_o),
        .colorpxls_bin2_o   (colorpxls_bin2_o),
        .colorpxls_bin3_o   (colorpxls_bin3_o),
        .colorpxls_bin4_o   (colorpxls_bin4_o),
        .colorpxls_bin5_o   (colorpxls_bin5_o),
        .colorpxls_bin6_o   (colorpxls_bin6_o),
        .colorpxls_bin7_o   (colorpxls_bin7_o),
        .colorpxls_left_o   (colorpxls_left_o),
        .colorpxls_rght_o   (colorpxls_rght_o),
        .colorpxls_bin012_o (colorpxls_bin012_o),
        .colorpxls_bin567_o (colorpxls_bin567_o),
        .colorpxls_bin01_o  (colorpxls_bin01_o),
        .colorpxls_bin67_o  (colorpxls_bin67_o),
        .new_frame_proc_o   (new_frame_proc_o)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    pulse_cnt = 0;
    int    mbin [8];
    int    pix_idx;
    int    exp_hold [15];
    int    obs [15];
    string onames [15] = '{"total", "bin0", "bin1", "bin2", "bin3", "bin4", "bin5",
                           "bin6", "bin7", "left", "rght", "bin012", "bin567",
                           "bin01", "bin67"};

    always_comb begin
        obs[0]  = int'(colorpxls_o);
        obs[1]  = int'(colorpxls_bin0_o);
        obs[2]  = int'(colorpxls_bin1_o);
        obs[3]  = int'(colorpxls_bin2_o);
        obs[4]  = int'(colorpxls_bin3_o);
        obs[5]  = int'(colorpxls_bin4_o);
        obs[6]  = int'(colorpxls_bin5_o);
        obs[7]  = int'(colorpxls_bin6_o);
        obs[8]  = int'(colorpxls_bin7_o);
        obs[9]  = int'(colorpxls_left_o);
        obs[10] = int'(colorpxls_rght_o);
        obs[11] = int'(colorpxls_bin012_o);
        obs[12] = int'(colorpxls_bin567_o);
        obs[13] = int'(colorpxls_bin01_o);
        obs[14] = int'(colorpxls_bin67_o);
    end

    always @(negedge clk) begin
        if (new_frame_proc_o === 1'b1) pulse_cnt++;
    end

    // Colour pattern per scenario, by image coordinate.
    function automatic bit color_of(input int mode, input int c, input int r);
        case (mode)
            0:       return 1'b1;
            1:       return (c >= 16) && (c <= 31);
            2:       return ((r < 8) || (c < 16) || (c >= 144)) ? bit'($urandom_range(1)) : 1'b0;
            3:       return (c == 143) && (r == 111);
            default: return bit'($urandom_range(1));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_pixel(input int mode);
        int c;
        int r;
        bit k;
        c = pix_idx % 160;
        r = pix_idx / 160;
        k = color_of(mode, c, r);
        px_valid_i = 1'b1;
        px_color_i = k;
        if (k && (c >= 16) && (c < 144) && (r >= 8) && (r < 112)) mbin[(c - 16) / 16]++;
        pix_idx++;
    endtask

    task automatic run_pixels(input int mode, input int n, input int gap_mod);
        for (int i = 0; i < n; i++) begin
            if (gap_mod > 0 && $urandom_range(gap_mod - 1) == 0) begin
                px_valid_i = 1'b0;
                px_color_i = bit'($urandom_range(1));
                repeat (1 + $urandom_range(2)) step();
            end
            put_pixel(mode);
            step();
        end
        px_valid_i = 1'b0;
        px_color_i = 1'b0;
    endtask

    task automatic begin_frame(input bit with_px, input int mode);
        frame_start_i = 1'b1;
        for (int b = 0; b < 8; b++) mbin[b] = 0;
        pix_idx = 0;
        if (with_px) put_pixel(mode);
        else px_valid_i = 1'b0;
        step();
        frame_start_i = 1'b0;
        px_valid_i    = 1'b0;
    endtask

    task automatic snapshot();
        int l;
        int rr;
        l  = mbin[0] + mbin[1] + mbin[2] + mbin[3];
        rr = mbin[4] + mbin[5] + mbin[6] + mbin[7];
        exp_hold[0] = l + rr;
        for (int b = 0; b < 8; b++) exp_hold[1 + b] = mbin[b];
        exp_hold[9]  = l;
        exp_hold[10] = rr;
        exp_hold[11] = mbin[0] + mbin[1] + mbin[2];
        exp_hold[12] = mbin[5] + mbin[6] + mbin[7];
        exp_hold[13] = mbin[0] + mbin[1];
        exp_hold[14] = mbin[6] + mbin[7];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start_i = 1'b0;
        px_valid_i = 1'b0;
        px_color_i = 1'b0;
        for (int b = 0; b < 8; b++) mbin[b] = 0;
        snapshot();
        repeat (3) step();
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL reset %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        checks++;
        if (new_frame_proc_o !== 1'b0) begin
            errors++;
            $display("FAIL reset pulse: got %b expected 0", new_frame_proc_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_all_colored();
        int p0;
        p0 = pulse_cnt;
        begin_frame(1'b0, 0);
        run_pixels(0, 19200, 0);
        snapshot();
        checks++;
        if (new_frame_proc_o !== 1'b0) begin
            errors++;
            $display("FAIL full early_pulse: got %b expected 0", new_frame_proc_o);
        end
        step();
        checks++;
        if (new_frame_proc_o !== 1'b1) begin
            errors++;
            $display("FAIL full pulse: got %b expected 1", new_frame_proc_o);
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL full %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        checks++;
        if (obs[0] !== 13312 || obs[1] !== 1664 || obs[9] !== 6656 || obs[11] !== 4992) begin
            errors++;
            $display("FAIL full consts: total %0d bin0 %0d left %0d bin012 %0d expected 13312 1664 6656 4992",
                     obs[0], obs[1], obs[9], obs[11]);
        end
        step();
        checks++;
        if (new_frame_proc_o !== 1'b0) begin
            errors++;
            $display("FAIL full pulse_width: got %b expected 0", new_frame_proc_o);
        end
        // Pixels arriving while idle must not disturb anything.
        for (int i = 0; i < 40; i++) begin
            px_valid_i = 1'b1;
            px_color_i = 1'b1;
            step();
        end
        px_valid_i = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL idle_hold %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        checks++;
        if (pulse_cnt !== p0 + 1) begin
            errors++;
            $display("FAIL full pulse_count: got %0d expected %0d", pulse_cnt - p0, 1);
        end
    endtask

    task automatic test_done_restart();
        int p0;
        p0 = pulse_cnt;
        begin_frame(1'b1, 2);
        run_pixels(2, 19199, 0);
        snapshot();
        // Start the next frame in the DONE cycle, with its first pixel.
        begin_frame(1'b1, 1);
        checks++;
        if (new_frame_proc_o !== 1'b1) begin
            errors++;
            $display("FAIL restart pulse: got %b expected 1", new_frame_proc_o);
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL edge %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        run_pixels(1, 19199, 0);
        snapshot();
        step();
        checks++;
        if (new_frame_proc_o !== 1'b1) begin
            errors++;
            $display("FAIL bin0 pulse: got %b expected 1", new_frame_proc_o);
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL bin0 %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        checks++;
        if (obs[1] !== 1664 || obs[0] !== 1664 || obs[10] !== 0 || obs[13] !== 1664) begin
            errors++;
            $display("FAIL bin0 consts: bin0 %0d total %0d rght %0d bin01 %0d expected 1664 1664 0 1664",
                     obs[1], obs[0], obs[10], obs[13]);
        end
        step();
        checks++;
        if (pulse_cnt !== p0 + 2) begin
            errors++;
            $display("FAIL restart pulse_count: got %0d expected %0d", pulse_cnt - p0, 2);
        end
    endtask

    task automatic test_abort();
        int p0;
        p0 = pulse_cnt;
        begin_frame(1'b0, 4);
        run_pixels(4, 5000, 4);
        repeat (2) step();
        checks++;
        if (pulse_cnt !== p0) begin
            errors++;
            $display("FAIL abort pulse_count: got %0d expected %0d", pulse_cnt - p0, 0);
        end
        begin_frame(1'b0, 3);
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL abort_hold %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        run_pixels(3, 19200, 16);
        snapshot();
        step();
        checks++;
        if (new_frame_proc_o !== 1'b1) begin
            errors++;
            $display("FAIL single pulse: got %b expected 1", new_frame_proc_o);
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL single %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        checks++;
        if (obs[8] !== 1 || obs[0] !== 1 || obs[10] !== 1 || obs[14] !== 1 || obs[1] !== 0) begin
            errors++;
            $display("FAIL single consts: bin7 %0d total %0d rght %0d bin67 %0d bin0 %0d expected 1 1 1 1 0",
                     obs[8], obs[0], obs[10], obs[14], obs[1]);
        end
        step();
    endtask

    task automatic test_reset_midframe();
        int p0;
        p0 = pulse_cnt;
        begin_frame(1'b0, 4);
        run_pixels(4, 3000, 0);
        rst = 1'b1;
        for (int b = 0; b < 8; b++) mbin[b] = 0;
        snapshot();
        #2;
        // Asynchronous: outputs clear before the next clock edge.
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL async_rst %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            px_valid_i = 1'b1;
            px_color_i = 1'b1;
            step();
        end
        px_valid_i = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (obs[k] !== exp_hold[k]) begin
                errors++;
                $display("FAIL post_rst %s: got %0d expected %0d", onames[k], obs[k], exp_hold[k]);
            end
        end
        checks++;
        if (pulse_cnt !== p0) begin
            errors++;
            $display("FAIL post_rst pulse_count: got %0d expected %0d", pulse_cnt - p0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_all_colored();
        test_done_restart();
        test_abort();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/color_histogram.md
COLOR_HISTOGRAM -- requirements
Module: color_histogram

Interface
REQ-001 The block SHALL have parameter c_img_cols, default 160, giving image columns per row.
REQ-002 The block SHALL have parameter c_img_rows, default 120, giving image rows per frame.
REQ-003 The block SHALL have parameter c_inframe_cols, default 128, giving inner-frame columns, centred (offset (c_img_cols-c_inframe_cols)/2 = 16).
REQ-004 The block SHALL have parameter c_inframe_rows, default 104, giving inner-frame rows, centred (offset 8).
REQ-005 The block SHALL have parameter c_hist_bins, default 8, giving column bins of c_inframe_cols/c_hist_bins = 16 columns each.
REQ-006 The block SHALL have port clk, input, 1 bit: clock.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port frame_start_i, input, 1 bit: one-cycle pulse marking the start of a frame.
REQ-009 The block SHALL have port px_valid_i, input, 1 bit: a pixel is present this cycle.
REQ-010 The block SHALL have port px_color_i, input, 1 bit: the present pixel passed the colour filter.
REQ-011 The block SHALL have port colorpxls_o, output, 14 bits: colour-pixel count over the inner frame.
REQ-012 The block SHALL have ports colorpxls_bin0_o .. colorpxls_bin7_o, output, 11 bits each: per-bin colour-pixel counts.
REQ-013 The block SHALL have ports colorpxls_left_o (bins 0-3) and colorpxls_rght_o (bins 4-7), output, 13 bits each.
REQ-014 The block SHALL have ports colorpxls_bin012_o, colorpxls_bin567_o, colorpxls_bin01_o and colorpxls_bin67_o, output, 13 bits each: partial sums.
REQ-015 The block SHALL have port new_frame_proc_o, output, 1 bit: one-cycle pulse when all outputs hold a new completed frame.

Function
REQ-016 Pixels SHALL arrive row-major; internal col (8 bit) and row (7 bit) counters SHALL index the pixel accepted on each px_valid_i cycle.
REQ-017 FSM states SHALL be IDLE, CAPTURE and DONE.
REQ-018 In IDLE, px_valid_i SHALL be ignored; frame_start_i SHALL move to CAPTURE.
REQ-019 frame_start_i SHALL clear col, row and all accumulators in every state, and SHALL enter CAPTURE.
REQ-020 A px_valid_i in the same cycle as frame_start_i SHALL be accepted as pixel (col 0, row 0).
REQ-021 In CAPTURE, each accepted pixel SHALL increment col; col SHALL wrap 159->0 and increment row.
REQ-022 A pixel with px_color_i=1, col in 16..143 and row in 8..111 SHALL increment bin accumulator (col-16)>>4; all other pixels SHALL not be counted.
REQ-023 Acceptance of pixel (col 159, row 119) SHALL include its contribution and move the FSM to DONE on the same edge.
REQ-024 In DONE (one cycle), the next edge SHALL load all outputs from the accumulators, assert new_frame_proc_o for exactly one cycle, and return to IDLE.
REQ-025 Sums and total SHALL be computed from the final bin values; they SHALL be exact and non-saturating (max total 13312, bin 1664, half 6656).
REQ-026 Outputs SHALL hold their values until the next completed frame.
REQ-027 frame_start_i during CAPTURE SHALL abort the frame and restart; no pulse SHALL be issued, and outputs SHALL retain the prior frame.
REQ-028 frame_start_i in the DONE cycle SHALL still complete the output load and pulse, and SHALL start a fresh CAPTURE.
REQ-029 Idle gaps in px_valid_i SHALL not affect results.
REQ-030 px_valid_i in IDLE after frame completion SHALL be ignored.

Reset
REQ-031 rst SHALL force the FSM to IDLE and clear all counters, accumulators and outputs to 0, including new_frame_proc_o.
REQ-032 Reset mid-CAPTURE SHALL discard the partial frame; processing SHALL resume only at the next frame_start_i.

Verification
REQ-033 All pixels coloured, full frame -> colorpxls_o=13312, every bin=1664, left=rght=6656, bin012=bin567=4992, bin01=bin67=3328, one pulse 2 edges after the last pixel.
REQ-034 Only cols 16-31 coloured (all rows) -> bin0=1664, other bins 0, left=bin01=bin012=1664, rght=0, colorpxls_o=1664.
REQ-035 Coloured pixels only at rows 0-7 and cols 0-15 / 144-159 -> all outputs 0, pulse still issued.
REQ-036 frame_start_i after 5000 pixels -> no pulse, outputs unchanged; the following full frame is counted from zero.
REQ-037 rst asserted mid-frame -> all outputs 0, no pulse; pixels ignored until frame_start_i.
REQ-038 Single coloured pixel at (col 143, row 111), random px_valid_i gaps -> bin7=1, rght=bin567=bin67=1, colorpxls_o=1.
